prio_grant_decoder: RTL and testbench

Registered decode-and-grant stage that sits on the receive side of the priority encoder's shared tri-state request bus. It accepts the encoder's index and valid, and drives a one-hot grant back to the winning requester. It holds that grant until the requester drops its request or a hold timeout expires. It then forces one idle turnaround cycle before any new grant, so grant-gated tri-state drivers never overlap.

---
 rtl/prio_grant_decoder.sv | 128 ++++++++++++
 tb/tb_prio_grant_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_grant_decoder.sv
// prio_grant_decoder
//   Registered decode-and-grant stage on the receive side of the priority
//   encoder's shared request bus. It latches the encoded winner index and
//   drives a one-hot grant back to that requester. The grant is held until
//   the requester drops its request or a hold timeout expires. One idle
//   turnaround cycle always follows a grant, so grant-gated tri-state drivers
//   never overlap.
//
// Ports
//   clk            clock, all state updates on its rising edge
//   rst_n          asynchronous active-low reset
//   i_enc_idx      encoded winning requester index (IDXW bits)
//   i_enc_valid    i_enc_idx is meaningful; sampled only while idle
//   i_req          raw request lines (N bits), watched for release of the grant
//   o_grant        registered one-hot grant (N bits)
//   o_grant_valid  registered, equals |o_grant
//   o_busy         registered, high while granting and during the gap cycle
//   o_timeout_err  registered one-cycle pulse when a grant is force-released
module prio_grant_decoder #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDXW     = 2,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] i_enc_idx,
  input  logic            i_enc_valid,
  input  logic [N-1:0]    i_req,
  output logic [N-1:0]    o_grant,
  output logic            o_grant_valid,
  output logic            o_busy,
  output logic            o_timeout_err
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e          r_state;
  logic [IDXW-1:0] r_g;
  logic [7:0]      r_hold_cnt;
  logic [N-1:0]    r_grant;
  logic            r_grant_valid;
  logic            r_busy;
  logic            r_timeout_err;

  state_e          w_state_d;
  logic [IDXW-1:0] w_g_d;
  logic [7:0]      w_hold_cnt_d;
  logic [N-1:0]    w_grant_d;
  logic            w_timeout_err_d;
  logic            w_idx_ok;
  logic            w_req_g;

  // Indices past the last requester are silently dropped.
  assign w_idx_ok = (32'(i_enc_idx) < N);

  // While granting, r_grant is exactly the one-hot of g, so it selects req[g].
  assign w_req_g = |(i_req & r_grant);

  always_comb begin
    w_state_d       = r_state;
    w_g_d           = r_g;
    w_hold_cnt_d    = r_hold_cnt;
    w_timeout_err_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_enc_valid && w_idx_ok) begin
          w_g_d        = i_enc_idx;
          w_hold_cnt_d = 8'd0;
          w_state_d    = StGrant;
        end
      end
      StGrant: begin
        // A release on the last allowed cycle wins over the timeout.
        if (!w_req_g) begin
          w_state_d = StGap;
        end else if (r_hold_cnt == HoldLast) begin
          w_state_d       = StGap;
          w_timeout_err_d = 1'b1;
        end else begin
          w_hold_cnt_d = r_hold_cnt + 8'd1;
        end
      end
      StGap: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs are computed from the next state so they appear registered,
  // with no combinational path from inputs.
  always_comb begin
    w_grant_d = '0;
    for (int i = 0; i < N; i++) begin
      w_grant_d[i] = (w_state_d == StGrant) && (w_g_d == IDXW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_g           <= '0;
      r_hold_cnt    <= 8'd0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_g           <= w_g_d;
      r_hold_cnt    <= w_hold_cnt_d;
      r_grant       <= w_grant_d;
      r_grant_valid <= (w_state_d == StGrant);
      r_busy        <= (w_state_d != StIdle);
      r_timeout_err <= w_timeout_err_d;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_prio_grant_decoder.sv
module tb_prio_grant_decoder;

  localparam int unsigned N        = 4;
  localparam int unsigned IDXW     = 3;
  localparam int unsigned MAX_HOLD = 15;

  logic            clk;
  logic            rst_n;
  logic [IDXW-1:0] enc_idx;
  logic            enc_valid;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic            busy;
  logic            timeout_err;

  typedef struct packed {
    logic [N-1:0] g;
    logic         v;
    logic         b;
    logic         t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  prio_grant_decoder #(
    .N        (N),
    .IDXW     (IDXW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enc_idx     (enc_idx),
    .i_enc_valid   (enc_valid),
    .i_req         (req),
    .o_grant       (grant),
    .o_grant_valid (grant_valid),
    .o_busy        (busy),
    .o_timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam exp_t Zero = '{g: 4'b0000, v: 1'b0, b: 1'b0, t: 1'b0};
  localparam exp_t Gap  = '{g: 4'b0000, v: 1'b0, b: 1'b1, t: 1'b0};

  function automatic exp_t granted(input logic [N-1:0] g);
    granted = '{g: g, v: 1'b1, b: 1'b1, t: 1'b0};
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b1; enc_idx = '0; enc_valid = 1'b0; req = '0;
    #2 rst_n = 1'b0;
    exp_q.push_back(Zero);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({grant, grant_valid, busy, timeout_err} !== e) begin
      errors++;
      $display("FAIL reset_async got %b%b%b%b exp %b", grant, grant_valid, busy, timeout_err, e);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      exp_q.push_back(Zero);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_valid, busy, timeout_err} !== e) begin
        errors++;
        $display("FAIL reset_idle c%0d got %b%b%b%b exp %b", c, grant, grant_valid, busy,
                 timeout_err, e);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    for (int c = 1; c <= 6; c++) begin
      enc_idx   = 3'd2;
      enc_valid = (c == 1);
      req       = (c <= 4) ? 4'b0100 : 4'b0000;
      if (c <= 4)      exp_q.push_back(granted(4'b0100));
      else if (c == 5) exp_q.push_back(Gap);
      else             exp_q.push_back(Zero);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_valid, busy, timeout_err} !== e) begin
        errors++;
        $display("FAIL single c%0d got %b%b%b%b exp %b", c, grant, grant_valid, busy,
                 timeout_err, e);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int c = 1; c <= 20; c++) begin
      enc_idx   = 3'd1;
      enc_valid = (c <= 18);
      req       = (c <= 18) ? 4'b0010 : 4'b0000;
      if (c <= 15)      exp_q.push_back(granted(4'b0010));
      else if (c == 16) exp_q.push_back('{g: 4'b0000, v: 1'b0, b: 1'b1, t: 1'b1});
      else if (c == 17) exp_q.push_back(Zero);
      else if (c == 18) exp_q.push_back(granted(4'b0010));
      else if (c == 19) exp_q.push_back(Gap);
      else              exp_q.push_back(Zero);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_valid, busy, timeout_err} !== e) begin
        errors++;
        $display("FAIL timeout c%0d got %b%b%b%b exp %b", c, grant, grant_valid, busy,
                 timeout_err, e);
      end
    end
  endtask

  task automatic test_index_change();
    exp_t e;
    for (int c = 1; c <= 8; c++) begin
      enc_idx   = (c == 1) ? 3'd0 : 3'd3;
      enc_valid = (c <= 6);
      req       = (c <= 3) ? 4'b0001 : 4'b0000;
      if (c <= 3)      exp_q.push_back(granted(4'b0001));
      else if (c == 4) exp_q.push_back(Gap);
      else if (c == 5) exp_q.push_back(Zero);
      else if (c == 6) exp_q.push_back(granted(4'b1000));
      else if (c == 7) exp_q.push_back(Gap);
      else             exp_q.push_back(Zero);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_valid, busy, timeout_err} !== e) begin
        errors++;
        $display("FAIL idx_change c%0d got %b%b%b%b exp %b", c, grant, grant_valid, busy,
                 timeout_err, e);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    for (int c = 1; c <= 17; c++) begin
      enc_idx   = 3'd2;
      enc_valid = (c == 1);
      req       = (c <= 15) ? 4'b0100 : 4'b0000;
      if (c <= 15)      exp_q.push_back(granted(4'b0100));
      else if (c == 16) exp_q.push_back(Gap);
      else              exp_q.push_back(Zero);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_valid, busy, timeout_err} !== e) begin
        errors++;
        $display("FAIL collision c%0d got %b%b%b%b exp %b", c, grant, grant_valid, busy,
                 timeout_err, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    for (int c = 1; c <= 4; c++) begin
      enc_idx   = (c == 4) ? 3'd7 : 3'd5;
      enc_valid = 1'b1;
      req       = 4'b1111;
      exp_q.push_back(Zero);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_valid, busy, timeout_err} !== e) begin
        errors++;
        $display("FAIL out_of_range c%0d got %b%b%b%b exp %b", c, grant, grant_valid, busy,
                 timeout_err, e);
      end
    end
    enc_valid = 1'b0;
    req       = '0;
  endtask

  task automatic test_reset_mid_grant();
    exp_t e;
    for (int c = 1; c <= 3; c++) begin
      enc_idx   = 3'd1;
      enc_valid = 1'b1;
      req       = 4'b0010;
      exp_q.push_back(granted(4'b0010));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_valid, busy, timeout_err} !== e) begin
        errors++;
        $display("FAIL rst_mid_pre c%0d got %b%b%b%b exp %b", c, grant, grant_valid, busy,
                 timeout_err, e);
      end
    end
    #2 rst_n = 1'b0;
    exp_q.push_back(Zero);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({grant, grant_valid, busy, timeout_err} !== e) begin
      errors++;
      $display("FAIL rst_mid_async got %b%b%b%b exp %b", grant, grant_valid, busy,
               timeout_err, e);
    end
    enc_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      exp_q.push_back(Zero);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, grant_valid, busy, timeout_err} !== e) begin
        errors++;
        $display("FAIL rst_mid_post c%0d got %b%b%b%b exp %b", c, grant, grant_valid, busy,
                 timeout_err, e);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_index_change();
    test_collision();
    test_out_of_range();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
